// File: rtl/byte_add_seq_pkg.sv
// Shared widths, state encoding and sum-combine helper for the byte add sequencer.
package byte_add_seq_pkg;

    localparam int BYTE_W = 8;
    localparam int NIB_W  = 4;
    localparam int SUM_W  = 9;
    localparam int Q_W    = NIB_W + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        LOW  = ST_LOW,
        HIGH = ST_HIGH,
        DONE = ST_DONE
    } state_t;

    // High partial sum carries weight 16; the total tops out at 510, so 9 bits never overflow.
    function automatic logic [SUM_W-1:0] combine_sum(input logic [Q_W-1:0] q_hi,
                                                     input logic [Q_W-1:0] q_lo);
        return {q_hi, {NIB_W{1'b0}}} + SUM_W'(q_lo);
    endfunction

endpackage

// File: rtl/byte_add_seq.sv
// Walks one operand byte pair through an external nibble adder, low half then high half,
// and presents the combined 9-bit sum on a valid/ready output.
//
// state | meaning
// IDLE  | ready for operands; latches in_a/in_b on in_valid
// LOW   | nibble adder sees low nibbles; capture low partial sum
// HIGH  | nibble adder sees high nibbles; form full sum
// DONE  | out_valid held until the consumer takes the sum
module byte_add_seq
    import byte_add_seq_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BYTE_W-1:0]   in_a,
    input  logic [BYTE_W-1:0]   in_b,
    output logic [BYTE_W-1:0]   nib_a,
    output logic [BYTE_W-1:0]   nib_b,
    output logic                nib_ctrl,
    input  logic [Q_W-1:0]      nib_q,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SUM_W-1:0]    out_sum,
    output logic [CNT_W-1:0]    op_count
);

    state_t              state;
    logic [BYTE_W-1:0]   a_r;
    logic [BYTE_W-1:0]   b_r;
    logic [Q_W-1:0]      q_lo_r;
    logic [SUM_W-1:0]    sum_r;
    logic [CNT_W-1:0]    cnt_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_r    <= '0;
            b_r    <= '0;
            q_lo_r <= '0;
            sum_r  <= '0;
            cnt_r  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= in_a;
                        b_r   <= in_b;
                        state <= LOW;
                    end
                end
                LOW: begin
                    q_lo_r <= nib_q;
                    state  <= HIGH;
                end
                HIGH: begin
                    sum_r <= combine_sum(nib_q, q_lo_r);
                    state <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        cnt_r <= cnt_r + CNT_W'(1);
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake and adder-select outputs are pure decodes of the state register.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign nib_ctrl  = (state == HIGH);
    assign nib_a     = a_r;
    assign nib_b     = b_r;
    assign out_sum   = sum_r;
    assign op_count  = cnt_r;

endmodule

// File: tb/tb_byte_add_seq.sv
// Directed bench for byte_add_seq with a behavioural nibble adder; a second CNT_W=2 copy
// runs in lockstep to exercise op_count wrap.
module tb_byte_add_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       out_ready;

    logic       in_ready,  in_ready2;
    logic [7:0] nib_a,     nib_a2;
    logic [7:0] nib_b,     nib_b2;
    logic       nib_ctrl,  nib_ctrl2;
    logic [4:0] nib_q,     nib_q2;
    logic       out_valid, out_valid2;
    logic [8:0] out_sum,   out_sum2;
    logic [7:0] op_count;
    logic [1:0] op_count2;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    byte_add_seq #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .nib_a(nib_a), .nib_b(nib_b), .nib_ctrl(nib_ctrl),
        .nib_q(nib_q), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .op_count(op_count)
    );

    byte_add_seq #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .nib_a(nib_a2), .nib_b(nib_b2), .nib_ctrl(nib_ctrl2),
        .nib_q(nib_q2), .out_valid(out_valid2), .out_ready(out_ready),
        .out_sum(out_sum2), .op_count(op_count2)
    );

    // Nibble adder models
    assign nib_q  = nib_ctrl  ? ({1'b0, nib_a[7:4]}  + {1'b0, nib_b[7:4]})
                              : ({1'b0, nib_a[3:0]}  + {1'b0, nib_b[3:0]});
    assign nib_q2 = nib_ctrl2 ? ({1'b0, nib_a2[7:4]} + {1'b0, nib_b2[7:4]})
                              : ({1'b0, nib_a2[3:0]} + {1'b0, nib_b2[3:0]});

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time expired, required finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One transaction; stall cycles hold out_ready low in DONE while a competing in_valid is offered.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [8:0] exp_sum,
                         input int stall);
        out_ready = (stall == 0);
        chk("idle_in_ready", in_ready, 1);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        step();
        in_valid = 1'b0;
        chk("low_nib_ctrl", nib_ctrl, 0);
        chk("low_in_ready", in_ready, 0);
        chk("low_out_valid", out_valid, 0);
        chk("nib_a", nib_a, a);
        chk("nib_b", nib_b, b);
        step();
        chk("high_nib_ctrl", nib_ctrl, 1);
        chk("high_out_valid", out_valid, 0);
        step();
        chk("done_out_valid", out_valid, 1);
        chk("done_nib_ctrl", nib_ctrl, 0);
        chk("out_sum", out_sum, exp_sum);
        chk("out_sum2", out_sum2, exp_sum);
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            in_a = 8'h12;
            in_b = 8'h8F;
            step();
            chk("stall_out_valid", out_valid, 1);
            chk("stall_out_sum", out_sum, exp_sum);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_nib_a", nib_a, a);
            chk("stall_op_count", op_count, exp_cnt[7:0]);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        exp_cnt++;
        chk("post_out_valid", out_valid, 0);
        chk("post_in_ready", in_ready, 1);
        chk("op_count", op_count, exp_cnt[7:0]);
        chk("op_count_w2", op_count2, exp_cnt[1:0]);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] sum;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{8'h24, 8'h81, 9'h0A5};
        vecs[1] = '{8'hED, 8'h8C, 9'h179};
        vecs[2] = '{8'hF9, 8'hC6, 9'h1BF};
        vecs[3] = '{8'hE5, 8'h77, 9'h15C};
        vecs[4] = '{8'hFF, 8'hFF, 9'h1FE};
        vecs[5] = '{8'h00, 8'h00, 9'h000};
        vecs[6] = '{8'h0F, 8'h01, 9'h010};

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = 8'h00;
        in_b = 8'h00;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_nib_ctrl", nib_ctrl, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", in_ready, 1);

        // idle with out_ready high must not count anything
        step();
        chk("idle_ready_ignored", op_count, 0);

        for (int i = 0; i < 7; i++)
            do_op(vecs[i].a, vecs[i].b, vecs[i].sum, 0);

        // reset while in LOW discards the transaction and clears the counter
        in_valid = 1'b1;
        in_a = 8'hFF;
        in_b = 8'hFF;
        step();
        in_valid = 1'b0;
        chk("midlow_state_nib_ctrl", nib_ctrl, 0);
        chk("midlow_in_ready", in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_op_count", op_count, 0);
        chk("midrst_op_count2", op_count2, 0);
        chk("midrst_out_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("midrst_idle_out_valid", out_valid, 0);
            chk("midrst_idle_in_ready", in_ready, 1);
            chk("midrst_idle_nib_ctrl", nib_ctrl, 0);
        end

        // back-pressure, then the offered operands go through on their own
        do_op(8'h09, 8'h63, 9'h06C, 5);
        do_op(8'h12, 8'h8F, 9'h0A1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
